rf_cmd_seq: RTL and testbench

//  Command sequencer that sits directly upstream of the 4x8 register file and drives its RF_EN/RF_ADDR/RF_IN port.

---
 rtl/rf_cmd_seq.sv | 166 ++++++++++++++++
 tb/tb_rf_cmd_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_cmd_seq.sv
// Command sequencer in front of a small register file: READ/WRITE/ADD/SUB with valid/ready in and out.
// Define RF_CMD_SAT_EN to make ADD/SUB saturate instead of wrapping.
//
// state | meaning
// IDLE  | ready for a command; latches op/addr/data on cmd handshake
// EXEC  | one cycle: drives RF port, captures result into response regs
// RESP  | response valid until the consumer takes it
module rf_cmd_seq #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_flag,
    output logic              rf_en,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_in,
    input  logic [DATA_W-1:0] rf_out
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_SUB   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [1:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_flag_q;

    logic              latch_cmd;
    logic              capture_rsp;

    logic [DATA_W:0]   sum_w;
    logic [DATA_W:0]   diff_w;
    logic [DATA_W-1:0] exec_result;
    logic              exec_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // rf_en and rf_in are decoded from state so that reset removes them immediately
    always_comb begin
        state_nxt   = state;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rf_en       = 1'b0;
        rf_in       = '0;
        latch_cmd   = 1'b0;
        capture_rsp = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    latch_cmd = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (op_q != OP_READ) begin
                    rf_en = 1'b1;
                    rf_in = exec_result;
                end
                capture_rsp = 1'b1;
                state_nxt   = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Carry out of the sum and borrow out of the difference double as the saturation indication
    always_comb begin
        sum_w       = {1'b0, rf_out} + {1'b0, data_q};
        diff_w      = {1'b0, rf_out} - {1'b0, data_q};
        exec_result = rf_out;
        exec_flag   = 1'b0;
        case (op_q)
            OP_READ: begin
                exec_result = rf_out;
                exec_flag   = 1'b0;
            end
            OP_WRITE: begin
                exec_result = data_q;
                exec_flag   = 1'b0;
            end
            OP_ADD: begin
                exec_flag = sum_w[DATA_W];
`ifdef RF_CMD_SAT_EN
                exec_result = sum_w[DATA_W] ? {DATA_W{1'b1}} : sum_w[DATA_W-1:0];
`else
                exec_result = sum_w[DATA_W-1:0];
`endif
            end
            OP_SUB: begin
                exec_flag = diff_w[DATA_W];
`ifdef RF_CMD_SAT_EN
                exec_result = diff_w[DATA_W] ? {DATA_W{1'b0}} : diff_w[DATA_W-1:0];
`else
                exec_result = diff_w[DATA_W-1:0];
`endif
            end
            default: begin
                exec_result = rf_out;
                exec_flag   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= OP_READ;
            addr_q <= '0;
            data_q <= '0;
        end else if (latch_cmd) begin
            op_q   <= cmd_op;
            addr_q <= cmd_addr;
            data_q <= cmd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_q <= '0;
            rsp_flag_q <= 1'b0;
        end else if (capture_rsp) begin
            rsp_data_q <= exec_result;
            rsp_flag_q <= exec_flag;
        end
    end

    // Address register keeps driving the RF between commands
    assign rf_addr  = addr_q;
    assign rsp_data = rsp_data_q;
    assign rsp_flag = rsp_flag_q;

endmodule

// File: tb/tb_rf_cmd_seq.sv
// Directed bench for rf_cmd_seq with a 4x8 register file model and an expected-response queue.
// Expectations follow RF_CMD_SAT_EN when it is defined for the build.
module tb_rf_cmd_seq;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_SUB   = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [1:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_flag;
    logic       rf_en;
    logic [1:0] rf_addr;
    logic [7:0] rf_in;
    logic [7:0] rf_out;

    logic       rf_clr;
    logic [7:0] rf_mem [4];
    logic [7:0] model_rf [4];
    logic [8:0] exp_q [$];

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    rf_cmd_seq #(.DATA_W(8), .ADDR_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_flag  (rsp_flag),
        .rf_en     (rf_en),
        .rf_addr   (rf_addr),
        .rf_in     (rf_in),
        .rf_out    (rf_out)
    );

    // Register file: combinational read, write on rising edge, not touched by the sequencer reset
    assign rf_out = rf_mem[rf_addr];
    always @(posedge clk or posedge rf_clr) begin
        if (rf_clr) begin
            for (int i = 0; i < 4; i++) rf_mem[i] <= 8'h00;
        end else if (rf_en) begin
            rf_mem[rf_addr] <= rf_in;
        end
    end

    // Returns {flag, data}
    function automatic logic [8:0] model_op(input logic [1:0] op, input logic [7:0] cur, input logic [7:0] d);
        int s;
        case (op)
            OP_READ:  return {1'b0, cur};
            OP_WRITE: return {1'b0, d};
            OP_ADD: begin
                s = int'(cur) + int'(d);
`ifdef RF_CMD_SAT_EN
                if (s > 255) return {1'b1, 8'hFF};
`endif
                return {s > 255, s[7:0]};
            end
            default: begin
                s = int'(cur) - int'(d) + 256;
`ifdef RF_CMD_SAT_EN
                if (cur < d) return {1'b1, 8'h00};
`endif
                return {cur < d, s[7:0]};
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [1:0] addr, input logic [7:0] data);
        logic [8:0] e;
        bit got;
        e = model_op(op, model_rf[addr], data);
        exp_q.push_back(e);
        if (op != OP_READ) model_rf[addr] = e[7:0];
        @(negedge clk);
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            if (cmd_ready) got = 1'b1;
            else @(negedge clk);
        end
        check("cmd_accept_timeout", 32'(got), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("exec_rf_en", 32'(rf_en), 32'(op != OP_READ));
        check("exec_rf_addr", 32'(rf_addr), 32'(addr));
        if (op != OP_READ) check("exec_rf_in", 32'(rf_in), 32'(e[7:0]));
        check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        check("exec_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        check("latency_rsp_valid", 32'(rsp_valid), 32'd1);
        check("resp_rf_en", 32'(rf_en), 32'd0);
    endtask

    task automatic recv();
        logic [8:0] e;
        bit got;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            if (rsp_valid && rsp_ready) got = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("rsp_timeout", 32'(got), 32'd1);
        n_asserts++;
        assert (exp_q.size() > 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%0d expected=nonzero", exp_q.size());
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rsp_data", 32'(rsp_data), 32'(e[7:0]));
            check("rsp_flag", 32'(rsp_flag), 32'(e[8]));
        end
        @(posedge clk); #1;
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        rf_clr    = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_READ;
        cmd_addr  = 2'd0;
        cmd_data  = 8'h00;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) model_rf[i] = 8'h00;

        #12;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rf_en", 32'(rf_en), 32'd0);
        check("rst_rf_addr", 32'(rf_addr), 32'd0);
        check("rst_rf_in", 32'(rf_in), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_flag", 32'(rsp_flag), 32'd0);
        @(negedge clk);
        rf_clr = 1'b0;
        rst_n  = 1'b1;

        for (int a = 0; a < 4; a++) begin
            send(OP_READ, 2'(a), 8'h00);
            recv();
        end

        send(OP_WRITE, 2'd2, 8'h5A); recv();
        send(OP_READ,  2'd2, 8'h00); recv();
        send(OP_ADD,   2'd2, 8'h01); recv();

        send(OP_WRITE, 2'd1, 8'hF0); recv();
        send(OP_ADD,   2'd1, 8'h20); recv();
        send(OP_READ,  2'd1, 8'h00); recv();

        send(OP_WRITE, 2'd3, 8'h05); recv();
        send(OP_SUB,   2'd3, 8'h07); recv();
        send(OP_READ,  2'd3, 8'h00); recv();
        send(OP_WRITE, 2'd3, 8'h05); recv();
        send(OP_SUB,   2'd3, 8'h05); recv();
        send(OP_ADD,   2'd3, 8'hFF); recv();

        // Backpressure with a second command waiting
        rsp_ready = 1'b0;
        send(OP_WRITE, 2'd0, 8'h33);
        cmd_op    = OP_READ;
        cmd_addr  = 2'd0;
        cmd_data  = 8'h00;
        cmd_valid = 1'b1;
        exp_q.push_back(model_op(OP_READ, model_rf[0], 8'h00));
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_data", 32'(rsp_data), 32'h33);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        recv();
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("bp_second_exec", 32'(cmd_ready), 32'd0);
        check("bp_second_rf_en", 32'(rf_en), 32'd0);
        @(posedge clk); #1;
        recv();

        // Reset during EXEC of a write
        @(negedge clk);
        cmd_op    = OP_WRITE;
        cmd_addr  = 2'd0;
        cmd_data  = 8'hAA;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("midop_rf_en_before", 32'(rf_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midop_rf_en_dropped", 32'(rf_en), 32'd0);
        check("midop_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midop_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("midop_idle_rsp_valid", 32'(rsp_valid), 32'd0);
            check("midop_idle_cmd_ready", 32'(cmd_ready), 32'd1);
        end
        check("midop_rf_untouched", 32'(rf_mem[0]), 32'(model_rf[0]));
        send(OP_READ, 2'd0, 8'h00); recv();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
